// File: rtl/axi_ram_arb_pkg.sv
// Shared types and constants for the two-requester AXI-RAM command arbiter.
//   arb_state_t : arbiter FSM state (idle bubble between bursts / burst owner locked)
//   NUM_REQ     : number of front ends sharing the RAM backend
`timescale 1ns/1ps
package axi_ram_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

   localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/axi_ram_arb_tag_fifo.sv
// 1-bit tag FIFO that remembers which requester issued each accepted read beat,
// so in-order backend responses can be steered back to their owner.
// Ports:
//   clk, rst         clock, async active-high reset (FIFO emptied)
//   push, push_tag   enqueue a tag (ignored when full)
//   pop              dequeue the head tag (ignored when empty)
//   full, empty      occupancy flags from the current count
//   head             tag at the head of the FIFO
`timescale 1ns/1ps
module axi_ram_arb_tag_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic push_tag,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_tag;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi_ram_cmd_arb.sv
// 2:1 arbiter sharing one RAM backend between two AXI-RAM front ends.
// Grant is locked for a whole burst (until a beat with last=1 is accepted) and
// alternates round-robin between bursts, with a one-cycle idle bubble per burst.
// Read beats record their owner in a tag FIFO; in-order backend responses are
// routed to the FIFO head's owner. A response arriving with no tag outstanding
// is refused and sets the sticky err_orphan flag.
// Optional feature: define AXI_RAM_ARB_QOS_EN to let the higher s_cmd_qos win
// when both requesters contend in idle (ties fall back to round-robin).
// Ports:
//   clk, rst             clock, async active-high reset
//   s_cmd_*              per-requester command beats (id/addr/data/strb/qos/wr/rd/last), s_cmd_ready back
//   s_rd_resp_*          per-requester read response stream
//   m_cmd_*              muxed command to backend, m_cmd_ready from backend
//   m_rd_resp_*          backend read response stream
//   err_orphan           sticky: backend response with no outstanding tag
`timescale 1ns/1ps
module axi_ram_cmd_arb
   import axi_ram_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned STRB_WIDTH     = DATA_WIDTH/8,
   parameter int unsigned ID_WIDTH       = 8,
   parameter int unsigned TAG_FIFO_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [1:0][ID_WIDTH-1:0]         s_cmd_id,
   input  logic [1:0][ADDR_WIDTH-1:0]       s_cmd_addr,
   input  logic [1:0][DATA_WIDTH-1:0]       s_cmd_wr_data,
   input  logic [1:0][STRB_WIDTH-1:0]       s_cmd_wr_strb,
   input  logic [1:0][3:0]                  s_cmd_qos,
   input  logic [1:0]                       s_cmd_wr_en,
   input  logic [1:0]                       s_cmd_rd_en,
   input  logic [1:0]                       s_cmd_last,
   output logic [1:0]                       s_cmd_ready,
   output logic [1:0][DATA_WIDTH-1:0]       s_rd_resp_data,
   output logic [1:0]                       s_rd_resp_last,
   output logic [1:0]                       s_rd_resp_valid,
   input  logic [1:0]                       s_rd_resp_ready,
   output logic [ID_WIDTH-1:0]              m_cmd_id,
   output logic [ADDR_WIDTH-1:0]            m_cmd_addr,
   output logic [DATA_WIDTH-1:0]            m_cmd_wr_data,
   output logic [STRB_WIDTH-1:0]            m_cmd_wr_strb,
   output logic                             m_cmd_wr_en,
   output logic                             m_cmd_rd_en,
   output logic                             m_cmd_last,
   input  logic                             m_cmd_ready,
   input  logic [DATA_WIDTH-1:0]            m_rd_resp_data,
   input  logic                             m_rd_resp_last,
   input  logic                             m_rd_resp_valid,
   output logic                             m_rd_resp_ready,
   output logic                             err_orphan
);

   arb_state_t         state;
   logic               grant;
   logic               rr_ptr;
   logic [NUM_REQ-1:0] req;
   logic               pick;
   logic               blocked;
   logic               beat_acc;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_head;

   assign req = s_cmd_wr_en | s_cmd_rd_en;

   // Winner for the next burst, evaluated only while idle.
   always_comb begin
      pick = rr_ptr;
      if (req == 2'b01) begin
         pick = 1'b0;
      end else if (req == 2'b10) begin
         pick = 1'b1;
      end
`ifdef AXI_RAM_ARB_QOS_EN
      else if (req == 2'b11 && s_cmd_qos[0] != s_cmd_qos[1]) begin
         pick = (s_cmd_qos[1] > s_cmd_qos[0]);
      end
`endif
   end

`ifndef AXI_RAM_ARB_QOS_EN
   logic unused_qos;
   assign unused_qos = ^s_cmd_qos;
`endif

   // A read beat may only pass when its tag has somewhere to go; a pop in the
   // same cycle does not free the slot early.
   assign blocked   = (state == ARB_BURST) & s_cmd_rd_en[grant] & fifo_full;
   assign beat_acc  = m_cmd_ready & (m_cmd_wr_en | m_cmd_rd_en);
   assign fifo_push = beat_acc & m_cmd_rd_en;

   always_comb begin
      m_cmd_id      = '0;
      m_cmd_addr    = '0;
      m_cmd_wr_data = '0;
      m_cmd_wr_strb = '0;
      m_cmd_wr_en   = 1'b0;
      m_cmd_rd_en   = 1'b0;
      m_cmd_last    = 1'b0;
      s_cmd_ready   = '0;
      if (state == ARB_BURST) begin
         m_cmd_id           = s_cmd_id[grant];
         m_cmd_addr         = s_cmd_addr[grant];
         m_cmd_wr_data      = s_cmd_wr_data[grant];
         m_cmd_wr_strb      = s_cmd_wr_strb[grant];
         m_cmd_wr_en        = s_cmd_wr_en[grant] & ~blocked;
         m_cmd_rd_en        = s_cmd_rd_en[grant] & ~blocked;
         m_cmd_last         = s_cmd_last[grant];
         s_cmd_ready[grant] = m_cmd_ready & ~blocked;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ARB_IDLE;
         grant  <= 1'b0;
         rr_ptr <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (|req) begin
                  grant <= pick;
                  state <= ARB_BURST;
               end
            end
            ARB_BURST: begin
               if (beat_acc && m_cmd_last) begin
                  rr_ptr <= ~grant;
                  state  <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   always_comb begin
      s_rd_resp_valid = '0;
      s_rd_resp_data  = '0;
      s_rd_resp_last  = '0;
      m_rd_resp_ready = 1'b0;
      if (!fifo_empty) begin
         s_rd_resp_valid[fifo_head] = m_rd_resp_valid;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            s_rd_resp_data[i] = m_rd_resp_data;
            s_rd_resp_last[i] = m_rd_resp_last;
         end
         m_rd_resp_ready = s_rd_resp_ready[fifo_head];
      end
   end

   assign fifo_pop = m_rd_resp_valid & m_rd_resp_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_orphan <= 1'b0;
      end else if (m_rd_resp_valid && fifo_empty) begin
         err_orphan <= 1'b1;
      end
   end

   axi_ram_arb_tag_fifo #(
      .DEPTH (TAG_FIFO_DEPTH)
   ) u_tag_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .push_tag (grant),
      .pop      (fifo_pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (fifo_head)
   );

endmodule

// File: tb/tb_axi_ram_cmd_arb.sv
// Randomized scoreboard bench for axi_ram_cmd_arb. The stimulus process drives
// bursts from both requesters plus a backend model; expected command beats and
// read responses are queued as they are issued, and a separate monitor pops and
// compares them as the DUT presents beats/responses.
`timescale 1ns/1ps
module tb_axi_ram_cmd_arb;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int SW = 4;
   localparam int IW = 8;
   localparam int TD = 8;
   localparam int LIMIT = 30000;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [1:0][IW-1:0]    s_cmd_id;
   logic [1:0][AW-1:0]    s_cmd_addr;
   logic [1:0][DW-1:0]    s_cmd_wr_data;
   logic [1:0][SW-1:0]    s_cmd_wr_strb;
   logic [1:0][3:0]       s_cmd_qos;
   logic [1:0]            s_cmd_wr_en;
   logic [1:0]            s_cmd_rd_en;
   logic [1:0]            s_cmd_last;
   logic [1:0]            s_cmd_ready;
   logic [1:0][DW-1:0]    s_rd_resp_data;
   logic [1:0]            s_rd_resp_last;
   logic [1:0]            s_rd_resp_valid;
   logic [1:0]            s_rd_resp_ready;
   logic [IW-1:0]         m_cmd_id;
   logic [AW-1:0]         m_cmd_addr;
   logic [DW-1:0]         m_cmd_wr_data;
   logic [SW-1:0]         m_cmd_wr_strb;
   logic                  m_cmd_wr_en;
   logic                  m_cmd_rd_en;
   logic                  m_cmd_last;
   logic                  m_cmd_ready;
   logic [DW-1:0]         m_rd_resp_data;
   logic                  m_rd_resp_last;
   logic                  m_rd_resp_valid;
   logic                  m_rd_resp_ready;
   logic                  err_orphan;

   always #5 clk = ~clk;

   axi_ram_cmd_arb #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .STRB_WIDTH     (SW),
      .ID_WIDTH       (IW),
      .TAG_FIFO_DEPTH (TD)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .s_cmd_id        (s_cmd_id),
      .s_cmd_addr      (s_cmd_addr),
      .s_cmd_wr_data   (s_cmd_wr_data),
      .s_cmd_wr_strb   (s_cmd_wr_strb),
      .s_cmd_qos       (s_cmd_qos),
      .s_cmd_wr_en     (s_cmd_wr_en),
      .s_cmd_rd_en     (s_cmd_rd_en),
      .s_cmd_last      (s_cmd_last),
      .s_cmd_ready     (s_cmd_ready),
      .s_rd_resp_data  (s_rd_resp_data),
      .s_rd_resp_last  (s_rd_resp_last),
      .s_rd_resp_valid (s_rd_resp_valid),
      .s_rd_resp_ready (s_rd_resp_ready),
      .m_cmd_id        (m_cmd_id),
      .m_cmd_addr      (m_cmd_addr),
      .m_cmd_wr_data   (m_cmd_wr_data),
      .m_cmd_wr_strb   (m_cmd_wr_strb),
      .m_cmd_wr_en     (m_cmd_wr_en),
      .m_cmd_rd_en     (m_cmd_rd_en),
      .m_cmd_last      (m_cmd_last),
      .m_cmd_ready     (m_cmd_ready),
      .m_rd_resp_data  (m_rd_resp_data),
      .m_rd_resp_last  (m_rd_resp_last),
      .m_rd_resp_valid (m_rd_resp_valid),
      .m_rd_resp_ready (m_rd_resp_ready),
      .err_orphan      (err_orphan)
   );

   typedef struct {
      logic [IW-1:0] id;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic          wr;
      logic          last;
   } beat_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } rsp_t;

   beat_t exp_cmd [2][$];   // beats each requester has issued, in order
   rsp_t  exp_rsp [2][$];   // read data each requester must receive, in order
   rsp_t  be_q [$];         // backend's pending read responses
   bit    tagq [$];         // owners of read beats the backend still owes

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   bit          mon_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: applies the arbitration rules (burst lock, round-robin, optional
   // qos, full-FIFO read blocking, in-order response routing) to what it sees.
   initial begin : monitor
      bit    model_idle;
      bit    rr;
      bit    owner;
      bit    h;
      bit    blk;
      bit    pop_tag;
      bit    push_tag;
      logic [1:0] rq;
      beat_t e;
      rsp_t  er;
      model_idle = 1'b1;
      rr         = 1'b0;
      owner      = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            pop_tag  = 1'b0;
            push_tag = 1'b0;
            if (tagq.size() > 0) begin
               h = tagq[0];
               chk("resp_valid_route", 64'(s_rd_resp_valid),
                   64'(m_rd_resp_valid ? (h ? 2'b10 : 2'b01) : 2'b00));
               chk("resp_ready_route", 64'(m_rd_resp_ready), 64'(s_rd_resp_ready[h]));
               if (m_rd_resp_valid && s_rd_resp_ready[h]) begin
                  chk("resp_underflow", 64'(exp_rsp[h].size() == 0), 64'(0));
                  if (exp_rsp[h].size() > 0) begin
                     er = exp_rsp[h].pop_front();
                     chk("resp_data", 64'(s_rd_resp_data[h]), 64'(er.data));
                     chk("resp_last", 64'(s_rd_resp_last[h]), 64'(er.last));
                  end
                  pop_tag = 1'b1;
               end
            end else begin
               chk("resp_idle", 64'({s_rd_resp_valid, m_rd_resp_ready}), 64'(0));
            end

            rq = s_cmd_wr_en | s_cmd_rd_en;
            if (model_idle) begin
               chk("idle_bubble", 64'({m_cmd_wr_en, m_cmd_rd_en, s_cmd_ready}), 64'(0));
               if (rq != 2'b00) begin
                  if (rq == 2'b01) owner = 1'b0;
                  else if (rq == 2'b10) owner = 1'b1;
                  else begin
                     owner = rr;
`ifdef AXI_RAM_ARB_QOS_EN
                     if (s_cmd_qos[0] > s_cmd_qos[1]) owner = 1'b0;
                     else if (s_cmd_qos[1] > s_cmd_qos[0]) owner = 1'b1;
`endif
                  end
                  model_idle = 1'b0;
               end
            end else begin
               blk = s_cmd_rd_en[owner] && (tagq.size() == TD);
               chk("other_ready", 64'(s_cmd_ready[~owner]), 64'(0));
               chk("grant_ready", 64'(s_cmd_ready[owner]), 64'(m_cmd_ready && !blk));
               chk("m_enables", 64'({m_cmd_wr_en, m_cmd_rd_en}),
                   64'(blk ? 2'b00 : {s_cmd_wr_en[owner], s_cmd_rd_en[owner]}));
               if (m_cmd_ready && (m_cmd_wr_en || m_cmd_rd_en)) begin
                  chk("cmd_underflow", 64'(exp_cmd[owner].size() == 0), 64'(0));
                  if (exp_cmd[owner].size() > 0) begin
                     e = exp_cmd[owner].pop_front();
                     chk("cmd_fields", {3'b0, m_cmd_id, m_cmd_addr, m_cmd_wr_data, m_cmd_wr_strb, m_cmd_last},
                         {3'b0, e.id, e.addr, e.data, e.strb, e.last});
                     chk("cmd_dir", 64'(m_cmd_wr_en), 64'(e.wr));
                  end
                  if (m_cmd_rd_en) push_tag = 1'b1;
                  if (m_cmd_last) begin
                     rr         = ~owner;
                     model_idle = 1'b1;
                  end
               end
            end
            if (pop_tag) void'(tagq.pop_front());
            if (push_tag) tagq.push_back(owner);
         end
      end
   end

   initial begin : stim
      int unsigned bursts_left [2];
      int unsigned beats_left [2];
      int unsigned cyc;
      bit          cur_valid [2];
      bit          cur_rd [2];
      bit          fire [2];
      bit          rfire;
      bit          withhold;
      bit          all_done;
      logic [DW-1:0] d;
      beat_t       cur_b [2];
      beat_t       b;

      rst             = 1'b1;
      s_cmd_id        = '0;
      s_cmd_addr      = '0;
      s_cmd_wr_data   = '0;
      s_cmd_wr_strb   = '0;
      s_cmd_qos       = '0;
      s_cmd_wr_en     = '0;
      s_cmd_rd_en     = '0;
      s_cmd_last      = '0;
      s_rd_resp_ready = '0;
      m_cmd_ready     = 1'b0;
      m_rd_resp_data  = '0;
      m_rd_resp_last  = 1'b0;
      m_rd_resp_valid = 1'b0;
      for (int r = 0; r < 2; r++) begin
         bursts_left[r] = 30;
         beats_left[r]  = 0;
         cur_valid[r]   = 1'b0;
         cur_rd[r]      = 1'b0;
      end

      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctrl", 64'({m_cmd_wr_en, m_cmd_rd_en, m_cmd_last, s_cmd_ready, s_rd_resp_valid,
                             s_rd_resp_last, m_rd_resp_ready, err_orphan}), 64'(0));
      chk("reset_cmd", 64'({m_cmd_id, m_cmd_addr}), 64'(0));
      chk("reset_data", 64'(s_rd_resp_data), 64'(0));
      rst    = 1'b0;
      mon_en = 1'b1;

      cyc = 0;
      while (cyc < LIMIT) begin
         @(negedge clk);
         rfire = m_rd_resp_valid & m_rd_resp_ready;
         for (int r = 0; r < 2; r++) begin
            fire[r] = cur_valid[r] && s_cmd_ready[r];
            if (fire[r] && cur_rd[r]) begin
               d = $urandom;
               be_q.push_back('{d, cur_b[r].last});
               exp_rsp[r].push_back('{d, cur_b[r].last});
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         if (rfire) void'(be_q.pop_front());
         all_done = 1'b1;
         for (int r = 0; r < 2; r++) begin
            if (fire[r]) cur_valid[r] = 1'b0;
            if (!cur_valid[r]) begin
               if (beats_left[r] == 0 && bursts_left[r] > 0 && $urandom_range(0, 3) == 0) begin
                  beats_left[r] = $urandom_range(1, 10);
                  cur_rd[r]     = 1'($urandom_range(0, 1));
                  bursts_left[r]--;
               end
               if (beats_left[r] > 0 && $urandom_range(0, 4) != 0) begin
                  b.id   = IW'($urandom);
                  b.addr = AW'($urandom);
                  b.data = $urandom;
                  b.strb = SW'($urandom);
                  b.wr   = ~cur_rd[r];
                  b.last = (beats_left[r] == 1);
                  beats_left[r]--;
                  exp_cmd[r].push_back(b);
                  cur_b[r]     = b;
                  cur_valid[r] = 1'b1;
               end
            end
            s_cmd_id[r]      = cur_b[r].id;
            s_cmd_addr[r]    = cur_b[r].addr;
            s_cmd_wr_data[r] = cur_b[r].data;
            s_cmd_wr_strb[r] = cur_b[r].strb;
            s_cmd_last[r]    = cur_b[r].last;
            s_cmd_wr_en[r]   = cur_valid[r] & ~cur_rd[r];
            s_cmd_rd_en[r]   = cur_valid[r] & cur_rd[r];
            s_cmd_qos[r]     = 4'($urandom_range(0, 3));
            if (cur_valid[r] || beats_left[r] != 0 || bursts_left[r] != 0) all_done = 1'b0;
         end
         m_cmd_ready     = ($urandom_range(0, 3) != 0);
         s_rd_resp_ready = ($urandom_range(0, 2) != 0) ? 2'b11 : 2'($urandom);
         withhold        = (cyc >= 300 && cyc < 360) || (cyc >= 900 && cyc < 940);
         if (all_done && be_q.size() == 0 && tagq.size() == 0) begin
            m_rd_resp_valid = 1'b0;
            break;
         end
         if (be_q.size() > 0 && !withhold && $urandom_range(0, 3) != 0) begin
            m_rd_resp_valid = 1'b1;
            m_rd_resp_data  = be_q[0].data;
            m_rd_resp_last  = be_q[0].last;
         end else begin
            m_rd_resp_valid = 1'b0;
            m_rd_resp_data  = DW'($urandom);
         end
      end
      chk("drain_timeout", 64'(cyc >= LIMIT), 64'(0));
      mon_en = 1'b0;

      // Orphan response: refused, and the flag sticks until reset.
      s_cmd_wr_en     = '0;
      s_cmd_rd_en     = '0;
      s_rd_resp_ready = '1;
      m_rd_resp_valid = 1'b1;
      @(negedge clk);
      chk("orphan_pre_flag", 64'(err_orphan), 64'(0));
      chk("orphan_refused", 64'({m_rd_resp_ready, s_rd_resp_valid}), 64'(0));
      @(posedge clk);
      #1;
      chk("orphan_set", 64'(err_orphan), 64'(1));
      m_rd_resp_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("orphan_sticky", 64'(err_orphan), 64'(1));
      rst = 1'b1;
      #1;
      chk("orphan_cleared", 64'(err_orphan), 64'(0));

      // Contention straight out of reset: qos decides when enabled, else rr_ptr=0.
      s_cmd_id[0]   = 8'hA0;
      s_cmd_id[1]   = 8'hB1;
      s_cmd_wr_en   = 2'b11;
      s_cmd_last    = 2'b00;
      s_cmd_qos[0]  = 4'd2;
      s_cmd_qos[1]  = 4'd7;
      m_cmd_ready   = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
`ifdef AXI_RAM_ARB_QOS_EN
      chk("qos_winner", 64'(m_cmd_id), 64'(8'hB1));
`else
      chk("rr_winner_qos_ignored", 64'(m_cmd_id), 64'(8'hA0));
`endif
      chk("burst_beat_passes", 64'(m_cmd_wr_en), 64'(1));
      // Asynchronous reset mid-burst drops the grant immediately.
      rst = 1'b1;
      #1;
      chk("midburst_reset", 64'({m_cmd_wr_en, s_cmd_ready, m_cmd_id}), 64'(0));
      s_cmd_qos[1] = 4'd2;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("equal_qos_rr", 64'(m_cmd_id), 64'(8'hA0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
